// File: rtl/apb_arb_master.sv
// Two-requester APB master: round-robin arbitration, address decode check and
// ACCESS-phase timeout, with per-requester ack/done handshakes.
module apb_arb_master #(
   parameter logic [7:0]  ADDR_MAX = 8'h8C,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic       wr0,
   input  logic       wr1,
   input  logic [7:0] addr0,
   input  logic [7:0] addr1,
   input  logic [7:0] wdata0,
   input  logic [7:0] wdata1,
   output logic       ack0,
   output logic       ack1,
   output logic       done0,
   output logic       done1,
   output logic       err,
   output logic [7:0] rdata,
   output logic       psel,
   output logic       penable,
   output logic       pwrite,
   output logic [7:0] paddr,
   output logic [7:0] pwdata,
   input  logic       pready,
   input  logic [7:0] prdata
);
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t state, state_nxt;

   logic              ptr, ptr_nxt;
   logic              sel, sel_nxt;
   logic              wr_q, wr_nxt;
   logic [DATA_W-1:0] addr_q, addr_nxt;
   logic [DATA_W-1:0] wdata_q, wdata_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;

   logic              ack0_nxt, ack1_nxt, done0_nxt, done1_nxt, err_nxt;
   logic [DATA_W-1:0] rdata_nxt;
   logic              psel_nxt, penable_nxt, pwrite_nxt;
   logic [DATA_W-1:0] paddr_nxt, pwdata_nxt;

   logic              any_req, gnt1, decode_ok, timeout_hit, resp_sent;
   logic [DATA_W-1:0] gaddr;

   // Pointer selects the favoured requester only when both are asking
   assign any_req     = req0 | req1;
   assign gnt1        = req1 & (~req0 | ptr);
   assign gaddr       = gnt1 ? addr1 : addr0;
   assign decode_ok   = (gaddr <= ADDR_MAX);
   assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
   assign resp_sent   = done0 | done1;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; ACCESS only samples pready once penable is on the bus
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = decode_ok ? SETUP : RESP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (penable && (pready || timeout_hit)) state_nxt = RESP;
         RESP:    if (resp_sent) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs and request holding registers
   always_comb begin
      ptr_nxt     = ptr;
      sel_nxt     = sel;
      wr_nxt      = wr_q;
      addr_nxt    = addr_q;
      wdata_nxt   = wdata_q;
      cnt_nxt     = cnt;
      ack0_nxt    = 1'b0;
      ack1_nxt    = 1'b0;
      done0_nxt   = 1'b0;
      done1_nxt   = 1'b0;
      err_nxt     = err;
      rdata_nxt   = rdata;
      psel_nxt    = psel;
      penable_nxt = penable;
      pwrite_nxt  = pwrite;
      paddr_nxt   = paddr;
      pwdata_nxt  = pwdata;
      case (state)
         IDLE: begin
            if (any_req) begin
               ack0_nxt  = ~gnt1;
               ack1_nxt  = gnt1;
               sel_nxt   = gnt1;
               ptr_nxt   = ~gnt1;
               wr_nxt    = gnt1 ? wr1 : wr0;
               addr_nxt  = gaddr;
               wdata_nxt = gnt1 ? wdata1 : wdata0;
            end
         end
         SETUP: begin
            psel_nxt    = 1'b1;
            penable_nxt = 1'b0;
            pwrite_nxt  = wr_q;
            paddr_nxt   = addr_q;
            pwdata_nxt  = wdata_q;
            cnt_nxt     = '0;
         end
         ACCESS: begin
            if (!penable) begin
               penable_nxt = 1'b1;
               cnt_nxt     = '0;
            end else if (pready || timeout_hit) begin
               psel_nxt    = 1'b0;
               penable_nxt = 1'b0;
               done0_nxt   = ~sel;
               done1_nxt   = sel;
               err_nxt     = ~pready;
               rdata_nxt   = (pready && !wr_q) ? prdata : DATA_W'(0);
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         RESP: begin
            // Decode errors arrive here without a done yet
            if (!resp_sent) begin
               done0_nxt = ~sel;
               done1_nxt = sel;
               err_nxt   = 1'b1;
               rdata_nxt = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr     <= 1'b0;
         sel     <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt     <= '0;
         ack0    <= 1'b0;
         ack1    <= 1'b0;
         done0   <= 1'b0;
         done1   <= 1'b0;
         err     <= 1'b0;
         rdata   <= '0;
         psel    <= 1'b0;
         penable <= 1'b0;
         pwrite  <= 1'b0;
         paddr   <= '0;
         pwdata  <= '0;
      end else begin
         ptr     <= ptr_nxt;
         sel     <= sel_nxt;
         wr_q    <= wr_nxt;
         addr_q  <= addr_nxt;
         wdata_q <= wdata_nxt;
         cnt     <= cnt_nxt;
         ack0    <= ack0_nxt;
         ack1    <= ack1_nxt;
         done0   <= done0_nxt;
         done1   <= done1_nxt;
         err     <= err_nxt;
         rdata   <= rdata_nxt;
         psel    <= psel_nxt;
         penable <= penable_nxt;
         pwrite  <= pwrite_nxt;
         paddr   <= paddr_nxt;
         pwdata  <= pwdata_nxt;
      end
   end
endmodule
